// File: rtl/bip_loader_ctrl_if.sv
// Bus bundle between the BIP program loader and its surroundings: the UART rx/tx
// handshakes, the instruction-memory write port and the CPU run control.
// The master modport is the loader side. The slave modport is the environment
// side (UART pair, CPU, instruction memory).
interface bip_loader_ctrl_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int UART_DATA_SIZE = 8,
  parameter int ADDR_WIDTH     = 11
);
  // UART receiver side
  logic [UART_DATA_SIZE-1:0] i_rx_data;
  logic                      i_rx_done;
  // UART transmitter side
  logic [UART_DATA_SIZE-1:0] o_tx_data;
  logic                      o_tx_start;
  logic                      i_tx_done;
  // Instruction memory write port
  logic                      o_imem_we;
  logic [ADDR_WIDTH-1:0]     o_imem_addr;
  logic [DATA_WIDTH-1:0]     o_imem_data;
  // CPU control and result
  logic                      o_cpu_rst;
  logic                      o_cpu_en;
  logic                      i_cpu_halt;
  logic [DATA_WIDTH-1:0]     i_acc;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_cpu_halt, i_acc,
    output o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_data,
           o_cpu_rst, o_cpu_en
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_cpu_halt, i_acc,
    input  o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_data,
           o_cpu_rst, o_cpu_en
  );
endinterface

// File: rtl/bip_loader_ctrl.sv
// UART-side sequencer for the BIP core.
// It loads a program received as a byte stream into instruction memory. On the
// 'R' command it runs the CPU until halt, then returns the accumulator and the
// elapsed cycle count as four bytes. The CPU is held in reset outside RUN.
// Optional feature macro: LOADER_ACK_EN. When it is defined, each completed load
// is acknowledged with a single 0x06 byte sent from an extra ACK state.
module bip_loader_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int UART_DATA_SIZE = 8,
  parameter int INS_MEM_DEPTH  = 2048,
  parameter int ADDR_WIDTH     = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  bip_loader_ctrl_if.master bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LEN_H = 4'd1;
  localparam logic [3:0] S_LEN_L = 4'd2;
  localparam logic [3:0] S_INS_H = 4'd3;
  localparam logic [3:0] S_INS_L = 4'd4;
  localparam logic [3:0] S_WRITE = 4'd5;
  localparam logic [3:0] S_RUN   = 4'd6;
  localparam logic [3:0] S_TX    = 4'd7;
`ifdef LOADER_ACK_EN
  localparam logic [3:0] S_ACK   = 4'd8;
`endif

  localparam logic [UART_DATA_SIZE-1:0] CMD_LOAD = UART_DATA_SIZE'(8'h4C);
  localparam logic [UART_DATA_SIZE-1:0] CMD_RUN  = UART_DATA_SIZE'(8'h52);
  localparam int                        LEN_W    = 2 * UART_DATA_SIZE;

  logic [3:0]                state;
  logic [UART_DATA_SIZE-1:0] len_hi;     // N[15:8] while the length is being received
  logic [LEN_W-1:0]          count;      // words still to be written
  logic [ADDR_WIDTH-1:0]     addr;       // next instruction-memory write address
  logic [UART_DATA_SIZE-1:0] ins_hi;     // high byte of the word being assembled
  logic [15:0]               cyc;        // RUN cycle counter, saturating
  logic [7:0]                acc_lo;     // low accumulator byte kept for the second tx byte
  logic [1:0]                tx_idx;     // index of the result byte currently being sent

  logic [LEN_W-1:0]          len_word;
  logic [ADDR_WIDTH-1:0]     addr_inc;
  logic [15:0]               cyc_inc;
  logic [7:0]                tx_next_byte;
  logic                      load_finish;

  // Derived values: full length word, wrapping address, saturating cycle count,
  // the byte that follows the current result byte, and the load-complete condition.
  always_comb begin
    len_word     = {len_hi, bus.i_rx_data};
    addr_inc     = (addr == ADDR_WIDTH'(INS_MEM_DEPTH - 1)) ? '0 : addr + 1'b1;
    cyc_inc      = (cyc == 16'hFFFF) ? cyc : cyc + 16'd1;
    tx_next_byte = 8'h00;
    case (tx_idx)
      2'd0:    tx_next_byte = acc_lo;
      2'd1:    tx_next_byte = cyc[15:8];
      default: tx_next_byte = cyc[7:0];
    endcase
    load_finish = ((state == S_LEN_L) && bus.i_rx_done && (len_word == '0)) ||
                  ((state == S_WRITE) && (count == LEN_W'(1)));
  end

  // Main sequencer: protocol FSM plus all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state           <= S_IDLE;
      len_hi          <= '0;
      count           <= '0;
      addr            <= '0;
      ins_hi          <= '0;
      cyc             <= '0;
      acc_lo          <= '0;
      tx_idx          <= '0;
      bus.o_tx_data   <= '0;
      bus.o_tx_start  <= 1'b0;
      bus.o_imem_we   <= 1'b0;
      bus.o_imem_addr <= '0;
      bus.o_imem_data <= '0;
      bus.o_cpu_rst   <= 1'b1;
      bus.o_cpu_en    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      bus.o_imem_we  <= 1'b0;
      bus.o_tx_start <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.i_rx_done) begin
            if (bus.i_rx_data == CMD_LOAD) begin
              state <= S_LEN_H;
            end else if (bus.i_rx_data == CMD_RUN) begin
              state        <= S_RUN;
              cyc          <= '0;
              bus.o_cpu_rst <= 1'b0;
              bus.o_cpu_en  <= 1'b1;
            end
          end
        end

        S_LEN_H: begin
          if (bus.i_rx_done) begin
            len_hi <= bus.i_rx_data;
            state  <= S_LEN_L;
          end
        end

        S_LEN_L: begin
          if (bus.i_rx_done) begin
            count <= len_word;
            addr  <= '0;
            // A zero length finishes here; load_finish picks the exit state.
            state <= (len_word == '0) ? S_IDLE : S_INS_H;
          end
        end

        S_INS_H: begin
          if (bus.i_rx_done) begin
            ins_hi <= bus.i_rx_data;
            state  <= S_INS_L;
          end
        end

        S_INS_L: begin
          if (bus.i_rx_done) begin
            bus.o_imem_we   <= 1'b1;
            bus.o_imem_addr <= addr;
            bus.o_imem_data <= DATA_WIDTH'({ins_hi, bus.i_rx_data});
            state           <= S_WRITE;
          end
        end

        // The write strobe is visible during this cycle; bytes arriving now are dropped.
        S_WRITE: begin
          addr  <= addr_inc;
          count <= count - LEN_W'(1);
          state <= (count == LEN_W'(1)) ? S_IDLE : S_INS_H;
        end

        S_RUN: begin
          // The count includes the cycle in which halt is sampled.
          cyc <= cyc_inc;
          if (bus.i_cpu_halt) begin
            acc_lo         <= bus.i_acc[7:0];
            bus.o_cpu_en   <= 1'b0;
            bus.o_cpu_rst  <= 1'b1;
            bus.o_tx_start <= 1'b1;
            bus.o_tx_data  <= UART_DATA_SIZE'(bus.i_acc[15:8]);
            tx_idx         <= 2'd0;
            state          <= S_TX;
          end
        end

        S_TX: begin
          if (bus.i_tx_done) begin
            if (tx_idx == 2'd3) begin
              state <= S_IDLE;
            end else begin
              tx_idx         <= tx_idx + 2'd1;
              bus.o_tx_start <= 1'b1;
              bus.o_tx_data  <= UART_DATA_SIZE'(tx_next_byte);
            end
          end
        end

`ifdef LOADER_ACK_EN
        S_ACK: begin
          if (bus.i_tx_done) begin
            state <= S_IDLE;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase

      // Completion of a load, either by the last write or by a zero length.
      if (load_finish) begin
`ifdef LOADER_ACK_EN
        state          <= S_ACK;
        bus.o_tx_start <= 1'b1;
        bus.o_tx_data  <= UART_DATA_SIZE'(8'h06);
`else
        state <= S_IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bip_loader_ctrl.sv
// Self-checking bench for bip_loader_ctrl. Expected memory writes and tx bytes are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_bip_loader_ctrl;
  localparam int DW    = 16;
  localparam int UW    = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bip_loader_ctrl_if #(.DATA_WIDTH(DW), .UART_DATA_SIZE(UW), .ADDR_WIDTH(AW)) bus ();

  bip_loader_ctrl #(
    .DATA_WIDTH(DW), .UART_DATA_SIZE(UW), .INS_MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [26:0] wr_q[$];     // {addr, data}
  logic [7:0]  tx_q[$];
  logic [15:0] ld_words[$];
  logic        we_prev = 1'b0;
  int          en_cycles = 0;
  bit          tx_busy = 1'b0;
  bit          quiet = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: compares writes and transmitted bytes against the scoreboard.
  always @(negedge clk) begin
    if (bus.o_imem_we) begin
      logic [26:0] e;
      check_value("we_1cyc", we_prev, 1'b0);
      check_value("wr_expected", wr_q.size() != 0, 1'b1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check_value("wr_addr", bus.o_imem_addr, e[26:16]);
        check_value("wr_data", bus.o_imem_data, e[15:0]);
      end
      if (!quiet) $display("wr addr=%0d data=0x%04h", bus.o_imem_addr, bus.o_imem_data);
    end
    we_prev <= bus.o_imem_we;
    if (bus.o_cpu_en) en_cycles++;
    if (bus.o_tx_start) begin
      check_value("tx_expected", tx_q.size() != 0, 1'b1);
      if (tx_q.size() != 0) check_value("tx_byte", bus.o_tx_data, tx_q.pop_front());
      $display("tx byte=0x%02h", bus.o_tx_data);
    end
  end

  // UART transmitter model: finishes each byte a few cycles after its start pulse.
  initial begin
    logic [7:0] held;
    forever begin
      @(negedge clk);
      while (bus.o_tx_start) begin
        tx_busy = 1'b1;
        held = bus.o_tx_data;
        repeat (3) @(negedge clk);
        check_value("tx_stable", bus.o_tx_data, held);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
      end
      tx_busy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((wr_q.size() != 0 || tx_q.size() != 0 || tx_busy || bus.o_tx_start) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, "_drain"}, n < 4000, 1'b1);
    wr_q.delete();
    tx_q.delete();
    repeat (6) @(negedge clk);
  endtask

  // Load the words in ld_words; the write address wraps at the memory depth.
  task automatic load_prog(input int gap);
    int n = ld_words.size();
    for (int k = 0; k < n; k++) wr_q.push_back({AW'(k % DEPTH), ld_words[k]});
`ifdef LOADER_ACK_EN
    tx_q.push_back(8'h06);
`endif
    send_byte(8'h4C, gap);
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    for (int k = 0; k < n; k++) begin
      send_byte(ld_words[k][15:8], 0);
      send_byte(ld_words[k][7:0], 0);
      check_value("we_lat", bus.o_imem_we, 1'b1);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic run_prog(input logic [15:0] acc, input int halt_cycle, input bit inject);
    tx_q.push_back(acc[15:8]);
    tx_q.push_back(acc[7:0]);
    tx_q.push_back(8'(halt_cycle >> 8));
    tx_q.push_back(8'(halt_cycle));
    en_cycles = 0;
    send_byte(8'h52, 0);
    check_value("run_cpu_rst", bus.o_cpu_rst, 1'b0);
    check_value("run_cpu_en", bus.o_cpu_en, 1'b1);
    for (int i = 1; i < halt_cycle; i++) begin
      bus.i_rx_data = 8'h4C;
      bus.i_rx_done = inject && (i == 2);
      @(negedge clk);
    end
    bus.i_rx_done  = 1'b0;
    bus.i_cpu_halt = 1'b1;
    bus.i_acc      = acc;
    @(negedge clk);
    bus.i_cpu_halt = 1'b0;
    check_value("halt_cpu_en", bus.o_cpu_en, 1'b0);
    check_value("halt_cpu_rst", bus.o_cpu_rst, 1'b1);
    check_value("halt_tx_start", bus.o_tx_start, 1'b1);
    if (inject) begin
      @(negedge clk);
      send_byte(8'h4C, 0);
    end
    wait_drain("run");
    check_value("en_cycles", en_cycles, halt_cycle);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_rx_data  = '0;
    bus.i_rx_done  = 1'b0;
    bus.i_tx_done  = 1'b0;
    bus.i_cpu_halt = 1'b0;
    bus.i_acc      = '0;

    // Reset values
    #12;
    check_value("rst_cpu_rst", bus.o_cpu_rst, 1'b1);
    check_value("rst_cpu_en", bus.o_cpu_en, 1'b0);
    check_value("rst_tx_start", bus.o_tx_start, 1'b0);
    check_value("rst_tx_data", bus.o_tx_data, 8'h00);
    check_value("rst_we", bus.o_imem_we, 1'b0);
    check_value("rst_addr", bus.o_imem_addr, 11'd0);
    check_value("rst_data", bus.o_imem_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-word load
    ld_words = '{16'h0801, 16'h0000};
    load_prog(2);
    wait_drain("load2");

    // Run, halt on the fifth RUN cycle
    run_prog(16'h1234, 5, 1'b0);

    // Junk byte in IDLE: nothing expected
    send_byte(8'hAA, 2);
    wait_drain("junk");

    // Zero-length load
`ifdef LOADER_ACK_EN
    tx_q.push_back(8'h06);
`endif
    send_byte(8'h4C, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    wait_drain("zero_len");

    // Address wrap: 2049 words, word k = k
    quiet = 1'b1;
    ld_words.delete();
    for (int k = 0; k <= DEPTH; k++) ld_words.push_back(16'(k));
    load_prog(1);
    wait_drain("wrap");
    quiet = 1'b0;
    check_value("wrap_last_addr", bus.o_imem_addr, 11'd0);
    check_value("wrap_last_data", bus.o_imem_data, 16'h0800);

    // Bytes during RUN and TX are dropped; halt in the first RUN cycle
    run_prog(16'hBEEF, 1, 1'b1);
    run_prog(16'h00C3, 3, 1'b1);

    // Asynchronous reset after the high byte of a word
    send_byte(8'h4C, 1);
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'hAB, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("arst_cpu_rst", bus.o_cpu_rst, 1'b1);
    check_value("arst_we", bus.o_imem_we, 1'b0);
    check_value("arst_addr", bus.o_imem_addr, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hCD, 2);   // low byte of the aborted word: must not write
    wait_drain("arst");

    // Full load after reset
    ld_words = '{16'hA55A, 16'h0102, 16'hFFFF};
    load_prog(2);
    wait_drain("reload");
    run_prog(16'h7E81, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bip_loader_ctrl.md
# bip_loader_ctrl

UART-side sequencer for the BIP core. It receives a program over the UART receiver byte stream and writes it into instruction memory. On a host command it releases the CPU, runs it until halt, and returns the accumulator and the elapsed cycle count through the UART transmitter. It sits in the top level between the UART rx/tx pair and the BIP CPU/instruction memory. While it is not in its run state, it holds the CPU in reset.

## Interface
Parameters:
- DATA_WIDTH, 16, instruction/accumulator width
- UART_DATA_SIZE, 8, UART byte width
- INS_MEM_DEPTH, 2048, instruction memory words
- ADDR_WIDTH, 11, instruction address width (log2 INS_MEM_DEPTH)

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_rx_data  in  UART_DATA_SIZE  received byte, valid while i_rx_done is high
- i_rx_done  in  1  one-cycle pulse per received byte
- o_tx_data  out  UART_DATA_SIZE  byte to transmit
- o_tx_start  out  1  one-cycle pulse starting a transmission
- i_tx_done  in  1  one-cycle pulse when the transmitter is finished
- o_imem_we  out  1  instruction memory write strobe
- o_imem_addr  out  ADDR_WIDTH  write address
- o_imem_data  out  DATA_WIDTH  write data
- o_cpu_rst  out  1  synchronous CPU reset, active-high
- o_cpu_en  out  1  CPU clock enable
- i_cpu_halt  in  1  CPU decoded a HLT instruction (level)
- i_acc  in  DATA_WIDTH  CPU accumulator

## Operation
Host protocol:
- 0x4C ('L') load: followed by N_hi, N_lo, then N instructions. Each instruction is 2 bytes, high byte first.
- 0x52 ('R') run.
- Any other byte in IDLE is discarded.

States:
- IDLE
  - 'L' -> LEN_H
  - 'R' -> RUN
- LEN_H
  - on rx -> LEN_L
  - N[15:8] is latched
- LEN_L
  - on rx, N latched -> INS_H, or IDLE if N==0
  - the address counter is cleared
- INS_H
  - on rx, the high byte is latched -> INS_L
- INS_L
  - on rx -> WRITE
- WRITE (1 cycle)
  - asserts o_imem_we with o_imem_data={hi,lo} and o_imem_addr=addr
  - addr increments and the word count decrements
  - -> INS_H if words remain, else IDLE
- RUN
  - o_cpu_rst=0 and o_cpu_en=1
  - the cycle counter increments each RUN cycle
  - i_cpu_halt=1 latches i_acc and the counter -> TX
- TX
  - sends 4 bytes: acc[15:8], acc[7:0], cyc[15:8], cyc[7:0]
  - o_tx_start pulses per byte
  - the next byte is started the cycle after i_tx_done
  - after i_tx_done of the 4th byte -> IDLE

Rules and boundary conditions:
- i_rx_done is ignored in WRITE, RUN and TX; those bytes are dropped.
- The address wraps modulo INS_MEM_DEPTH when N > INS_MEM_DEPTH; later words overwrite earlier ones.
- The cycle counter is 16-bit, is cleared on entering RUN, and saturates at 0xFFFF.
- The cycle count includes the cycle in which halt is sampled. A CPU halting in its first RUN cycle therefore reports cyc=1.
- i_tx_done outside TX is ignored.
- Reset at any point:
  - the state returns to IDLE
  - any partially loaded word is discarded; no write is issued
  - the CPU is held in reset

## Timing
Reset values:
- o_cpu_rst=1
- all other outputs 0: o_cpu_en, o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data

Latencies:
- All outputs are registered.
- o_imem_we is high exactly 1 cycle, starting 1 cycle after the i_rx_done of the low byte.
- o_cpu_rst falls and o_cpu_en rises 1 cycle after the i_rx_done of 'R'.
- In the cycle after i_cpu_halt is sampled high:
  - o_cpu_en=0 and o_cpu_rst=1
  - the first o_tx_start pulse is issued
- o_tx_data is stable from o_tx_start until i_tx_done.
- Back-to-back load words run at the UART byte rate; there is no minimum gap beyond the WRITE cycle.

## Configuration
- LOADER_ACK_EN defined: after the last WRITE of a load, or after LEN_L with N==0, the block enters ACK.
  - ACK transmits the single byte 0x06, then returns to IDLE.
  - Rx bytes are ignored during ACK.
- LOADER_ACK_EN undefined: a load completes silently and returns directly to IDLE. The ACK state is not synthesized.

## Test plan
- Load 2 words: rx 0x4C, 0x00, 0x02, 0x08, 0x01, 0x00, 0x00.
  - Expect imem writes addr0=0x0801 and addr1=0x0000, each with a 1-cycle we.
  - With LOADER_ACK_EN, one tx byte 0x06.
- Run: rx 0x52; assert i_cpu_halt with i_acc=0x1234 on the 5th RUN cycle.
  - Expect tx bytes 0x12, 0x34, 0x00, 0x05.
  - Expect o_cpu_en high exactly 5 cycles.
- Junk and zero-length handling:
  - Rx 0xAA in IDLE -> no response.
  - Rx 0x4C, 0x00, 0x00 -> return to IDLE with no writes (ACK only if enabled).
- Wrap: load N=2049 with word k=k.
  - Expect the final write to addr 0 with data 0x0800.
- Bytes during RUN and TX are ignored: inject rx 0x4C while running.
  - Expect no writes.
  - Expect the 4-byte result to be unaffected.
- Async reset (i_rst low) after receiving INS_H.
  - Expect immediate IDLE, o_cpu_rst=1, no write.
  - A subsequent full load behaves normally.
